// File: rtl/bg_line_fetcher_if.sv
// Handshake and memory-port bundle for the background scanline fetcher.
// Master is the request/memory side; slave is the fetcher itself.
interface bg_line_fetcher_if;
   logic        line_start;
   logic [8:0]  line_num;
   logic        busy;
   logic        line_done;
   logic [8:0]  tb_addr;
   logic        tb_rw;
   logic [31:0] tb_read_data;
   logic [10:0] gfx_addr;
   logic        gfx_rw;
   logic [31:0] gfx_read_data;
   logic        lb_we;
   logic [6:0]  lb_addr;
   logic [31:0] lb_data;

   modport master (
      output line_start, line_num, tb_read_data, gfx_read_data,
      input  busy, line_done, tb_addr, tb_rw, gfx_addr, gfx_rw, lb_we, lb_addr, lb_data
   );

   modport slave (
      input  line_start, line_num, tb_read_data, gfx_read_data,
      output busy, line_done, tb_addr, tb_rw, gfx_addr, gfx_rw, lb_we, lb_addr, lb_data
   );
endinterface

// File: rtl/bg_line_fetcher.sv
// Background scanline fetcher: walks one tile row of the map, fetches 4 graphics
// words per tile, applies H/V flip and writes 80 packed words into the line buffer.
//
// state   | meaning
// S_IDLE  | waiting for an accepted line_start
// S_TILE  | tile buffer address for current column on the bus
// S_LATCH | map entry arriving; capture tile id / flips, issue first gfx word
// S_GFX   | gfx words 0..3 of the current tile issued, one per cycle
// S_DRAIN | last tile's writes still in the pipeline
module bg_line_fetcher #(
   parameter int TILES_PER_ROW = 20,
   parameter int VISIBLE_LINES = 480,
   parameter int HFLIP_BIT     = 4,
   parameter int VFLIP_BIT     = 5
) (
   input logic            clk,
   input logic            reset,
   bg_line_fetcher_if.slave bus
);

   localparam logic [8:0] LINE_LIMIT = 9'(VISIBLE_LINES);
   localparam logic [4:0] LAST_COL   = 5'(TILES_PER_ROW - 1);

   typedef enum logic [2:0] {S_IDLE, S_TILE, S_LATCH, S_GFX, S_DRAIN} state_t;

   state_t      state_q;
   logic        busy_q;
   logic        done_q;
   logic [8:0]  tb_addr_q;
   logic [10:0] gfx_addr_q;
   logic [4:0]  line_lo_q;
   logic [4:0]  col_q;
   logic [3:0]  tile_q;
   logic        hflip_q;
   logic [4:0]  trow_q;
   logic        drain_cnt_q;

   logic        p1_vld_q;
   logic [4:0]  p1_col_q;
   logic [1:0]  p1_w_q;
   logic        p1_hflip_q;

   logic        lb_we_q;
   logic [6:0]  lb_addr_q;
   logic [31:0] lb_data_q;

   logic [8:0]  row_base_d;
   logic [4:0]  trow_d;
   logic [6:0]  lb_addr_d;
   logic [31:0] lb_data_d;
   logic [31:0] rev_word;
   logic        unused_map;

   always_comb begin
      row_base_d = 9'(bus.line_num[8:5]) * 9'(TILES_PER_ROW);
      trow_d     = bus.tb_read_data[VFLIP_BIT] ? ~line_lo_q : line_lo_q;
      lb_addr_d  = {p1_col_q, (p1_hflip_q ? ~p1_w_q : p1_w_q)};
      rev_word   = '0;
      for (int p = 0; p < 8; p++) begin
         rev_word[4*p +: 4] = bus.gfx_read_data[4*(7-p) +: 4];
      end
      lb_data_d  = p1_hflip_q ? rev_word : bus.gfx_read_data;
   end

   // Only the tile id and flip bits of a map entry carry meaning.
   assign unused_map = ^bus.tb_read_data;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         tb_addr_q   <= '0;
         gfx_addr_q  <= '0;
         line_lo_q   <= '0;
         col_q       <= '0;
         tile_q      <= '0;
         hflip_q     <= 1'b0;
         trow_q      <= '0;
         drain_cnt_q <= 1'b0;
         p1_vld_q    <= 1'b0;
         p1_col_q    <= '0;
         p1_w_q      <= '0;
         p1_hflip_q  <= 1'b0;
         lb_we_q     <= 1'b0;
         lb_addr_q   <= '0;
         lb_data_q   <= '0;
      end else begin
         done_q     <= 1'b0;
         // Gfx data returns one cycle after issue and is written the cycle after that.
         p1_vld_q   <= (state_q == S_GFX);
         p1_col_q   <= col_q;
         p1_w_q     <= gfx_addr_q[1:0];
         p1_hflip_q <= hflip_q;
         lb_we_q    <= p1_vld_q;
         if (p1_vld_q) begin
            lb_addr_q <= lb_addr_d;
            lb_data_q <= lb_data_d;
         end

         case (state_q)
            S_IDLE: begin
               if (bus.line_start && (bus.line_num < LINE_LIMIT)) begin
                  state_q   <= S_TILE;
                  busy_q    <= 1'b1;
                  line_lo_q <= bus.line_num[4:0];
                  tb_addr_q <= row_base_d;
                  col_q     <= '0;
               end
            end
            S_TILE: begin
               state_q <= S_LATCH;
            end
            S_LATCH: begin
               tile_q     <= bus.tb_read_data[3:0];
               hflip_q    <= bus.tb_read_data[HFLIP_BIT];
               trow_q     <= trow_d;
               gfx_addr_q <= {bus.tb_read_data[3:0], trow_d, 2'd0};
               state_q    <= S_GFX;
            end
            S_GFX: begin
               if (gfx_addr_q[1:0] == 2'd3) begin
                  if (col_q == LAST_COL) begin
                     state_q     <= S_DRAIN;
                     drain_cnt_q <= 1'b1;
                  end else begin
                     col_q     <= col_q + 5'd1;
                     tb_addr_q <= tb_addr_q + 9'd1;
                     state_q   <= S_TILE;
                  end
               end else begin
                  gfx_addr_q <= {tile_q, trow_q, gfx_addr_q[1:0] + 2'd1};
               end
            end
            S_DRAIN: begin
               if (drain_cnt_q == 1'b0) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  drain_cnt_q <= 1'b0;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.busy      = busy_q;
   assign bus.line_done = done_q;
   assign bus.tb_addr   = tb_addr_q;
   assign bus.tb_rw     = 1'b0;
   assign bus.gfx_addr  = gfx_addr_q;
   assign bus.gfx_rw    = 1'b0;
   assign bus.lb_we     = lb_we_q;
   assign bus.lb_addr   = lb_addr_q;
   assign bus.lb_data   = lb_data_q;

endmodule
